// File: rtl/mem_access_ctrl.sv
// Request/response sequencer in front of the 32x32 memory: turns a valid/ready request stream into
// single-cycle memory strobes and returns read data on a valid/ready channel. Optional: MEM_RD_TIMEOUT_EN.
module mem_access_ctrl #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int CNT_W      = 16,
    parameter int RD_TIMEOUT = 8
) (
    input  logic              CLK,
    input  logic              Rst_n,
    input  logic              Req_Valid,
    output logic              Req_Ready,
    input  logic              Req_Write,
    input  logic [ADDR_W-1:0] Req_Addr,
    input  logic [DATA_W-1:0] Req_Data,
    output logic              Rsp_Valid,
    input  logic              Rsp_Ready,
    output logic [DATA_W-1:0] Rsp_Data,
    output logic              Rsp_Err,
    output logic              Mem_Wr_En,
    output logic              Mem_Rd_En,
    output logic [ADDR_W-1:0] Mem_Address,
    output logic [DATA_W-1:0] Mem_Data_in,
    input  logic [DATA_W-1:0] Mem_Data_out,
    input  logic              Mem_Valid_out,
    output logic [CNT_W-1:0]  Wr_Count,
    output logic [CNT_W-1:0]  Rd_Count
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WR   = 3'd1;
    localparam logic [2:0] S_RD   = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_RSP  = 3'd4;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    if (RD_TIMEOUT < 1) begin : g_bad_rd_timeout
        $error("RD_TIMEOUT must be at least 1");
    end

    logic [2:0]        state_q, state_d;
    logic              init_done_q;
    logic              wr_en_q, wr_en_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic              accept;

`ifdef MEM_RD_TIMEOUT_EN
    localparam int WCNT_W = $clog2(RD_TIMEOUT + 1);
    logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              rsp_err_q, rsp_err_d;
`endif

    // Requests are only taken in IDLE, and never in the first cycle out of reset.
    assign Req_Ready = (state_q == S_IDLE) && init_done_q;
    assign accept    = Req_Valid && Req_Ready;

    always_comb begin
        state_d     = state_q;
        wr_en_d     = 1'b0;
        rd_en_d     = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
`ifdef MEM_RD_TIMEOUT_EN
        wait_cnt_d  = wait_cnt_q;
        rsp_err_d   = rsp_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    addr_d = Req_Addr;
                    if (Req_Write) begin
                        wdata_d = Req_Data;
                        wr_en_d = 1'b1;
                        state_d = S_WR;
                    end else begin
                        rd_en_d = 1'b1;
                        state_d = S_RD;
                    end
                end
            end
            S_WR: begin
                wr_cnt_d = (wr_cnt_q == CNT_MAX) ? wr_cnt_q : wr_cnt_q + CNT_ONE;
                state_d  = S_IDLE;
            end
            S_RD: begin
                state_d = S_WAIT;
`ifdef MEM_RD_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
            end
            S_WAIT: begin
                if (Mem_Valid_out) begin
                    rsp_data_d  = Mem_Data_out;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RSP;
`ifdef MEM_RD_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
                // Memory never answered: return an errored, zero-data response instead of hanging.
                end else if (wait_cnt_q == WCNT_W'(RD_TIMEOUT - 1)) begin
                    rsp_data_d  = '0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    state_d     = S_RSP;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCNT_W'(1);
`endif
                end
            end
            S_RSP: begin
                if (Rsp_Ready) begin
                    rsp_valid_d = 1'b0;
                    rd_cnt_d    = (rd_cnt_q == CNT_MAX) ? rd_cnt_q : rd_cnt_q + CNT_ONE;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= S_IDLE;
            init_done_q <= 1'b0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            init_done_q <= 1'b1;
            wr_en_q     <= wr_en_d;
            rd_en_q     <= rd_en_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
        end
    end

`ifdef MEM_RD_TIMEOUT_EN
    always_ff @(posedge CLK or negedge Rst_n) begin
        if (!Rst_n) begin
            wait_cnt_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign Rsp_Err = rsp_err_q;
`else
    assign Rsp_Err = 1'b0;
`endif

    assign Mem_Wr_En   = wr_en_q;
    assign Mem_Rd_En   = rd_en_q;
    assign Mem_Address = addr_q;
    assign Mem_Data_in = wdata_q;
    assign Rsp_Valid   = rsp_valid_q;
    assign Rsp_Data    = rsp_data_q;
    assign Wr_Count    = wr_cnt_q;
    assign Rd_Count    = rd_cnt_q;

endmodule
